// File: rtl/gf_syndrome_accum.sv
// gf_syndrome_accum
// Streaming GF(2^M) syndrome calculator. Symbols arrive highest-degree first
// and every syndrome S_j = r(alpha^j), j = 1..NSYN, is built with its own Horner
// accumulator: acc_j <= acc_j * alpha^j + sym. When a frame ends, the final
// accumulators are registered onto syn_o together with an any-nonzero flag and
// a frame-too-long flag, and syn_valid_o pulses for one cycle.

module gf_syndrome_accum #(
  parameter int         M    = 4,
  parameter logic [M:0] POLY = 5'h13,
  parameter int         NSYN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid_i,
  input  logic [M-1:0]      sym_i,
  input  logic              sym_last_i,
  output logic [NSYN*M-1:0] syn_o,
  output logic              syn_valid_o,
  output logic              err_o,
  output logic              len_err_o,
  output logic              busy_o
);

  // The counter is one bit wider than a symbol so it can reach 2^M, the first
  // length that no longer fits in a codeword of 2^M-1 symbols.
  localparam logic [M:0] CNT_ONE = (M+1)'(1);
  localparam logic [M:0] CNT_MAX = {1'b1, {M{1'b0}}};

  typedef enum logic {
    IDLE,
    ACC
  } state_e;

  state_e                    state_q, state_d;
  logic [NSYN-1:0][M-1:0]    accum_q, accum_d;
  logic [NSYN-1:0][M-1:0]    stepVal;
  logic [M:0]                symCount_q, symCount_d;
  logic                      complete;

  logic [NSYN-1:0][M-1:0]    syn_q;
  logic                      synValid_q;
  logic                      err_q;
  logic                      lenErr_q;

  // Multiply by alpha: shift up one degree and fold the x^M term back in
  // through the primitive polynomial.
  function automatic logic [M-1:0] mulAlpha(input logic [M-1:0] x);
    logic [M-1:0] r;
    r = {x[M-2:0], 1'b0};
    if (x[M-1]) begin
      r = r ^ POLY[M-1:0];
    end
    return r;
  endfunction

  // Multiply by alpha^n as n cascaded mulAlpha stages. The loop bound is the
  // constant NSYN so the cascade unrolls to plain XOR logic; n is always a
  // per-syndrome constant, so unused stages fold away.
  function automatic logic [M-1:0] mulAlphaPow(input logic [M-1:0] x, input int n);
    logic [M-1:0] r;
    r = x;
    for (int i = 0; i < NSYN; i++) begin
      if (i < n) begin
        r = mulAlpha(r);
      end
    end
    return r;
  endfunction

  // One Horner step per syndrome; syndrome index j+1 multiplies by alpha^(j+1).
  for (genvar j = 0; j < NSYN; j++) begin : g_step
    assign stepVal[j] = mulAlphaPow(accum_q[j], j + 1) ^ sym_i;
  end

  // Next-state logic: load on the first symbol, step on every later symbol,
  // hold through gaps, and flag completion on a valid last symbol.
  always_comb begin
    state_d    = state_q;
    accum_d    = accum_q;
    symCount_d = symCount_q;
    complete   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sym_valid_i) begin
          accum_d    = {NSYN{sym_i}};
          symCount_d = CNT_ONE;
          state_d    = ACC;
          if (sym_last_i) begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end
      end
      ACC: begin
        if (sym_valid_i) begin
          accum_d = stepVal;
          if (symCount_q != CNT_MAX) begin
            symCount_d = symCount_q + CNT_ONE;
          end
          if (sym_last_i) begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame state: FSM, accumulators and symbol counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      accum_q    <= '0;
      symCount_q <= '0;
    end else begin
      state_q    <= state_d;
      accum_q    <= accum_d;
      symCount_q <= symCount_d;
    end
  end

  // Result registers: capture the final accumulators straight from the
  // next-state values so results appear one cycle after the last symbol,
  // leaving the accumulators free for a back-to-back frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syn_q      <= '0;
      synValid_q <= 1'b0;
      err_q      <= 1'b0;
      lenErr_q   <= 1'b0;
    end else begin
      synValid_q <= complete;
      if (complete) begin
        syn_q    <= accum_d;
        err_q    <= |accum_d;
        lenErr_q <= (symCount_d == CNT_MAX);
      end
    end
  end

  assign syn_o       = syn_q;
  assign syn_valid_o = synValid_q;
  assign err_o       = err_q;
  assign len_err_o   = lenErr_q;
  assign busy_o      = (state_q == ACC);

endmodule

// File: tb/tb_gf_syndrome_accum.sv
// tb_gf_syndrome_accum
// Directed frames with hand-computed syndromes for GF(16) (x^4+x+1, 4 syndromes)
// plus one frame on a GF(256) instance (x^8+x^4+x^3+x^2+1, 16 syndromes).
// GF(16) powers of alpha: 1 2 4 8 3 6 C B 5 A 7 E F D 9.

module tb_gf_syndrome_accum;

  logic         clk = 1'b0;
  logic         rst;

  logic         symValid;
  logic [3:0]   sym;
  logic         symLast;
  logic [15:0]  syn;
  logic         synValid;
  logic         err;
  logic         lenErr;
  logic         busy;

  logic         bSymValid;
  logic [7:0]   bSym;
  logic         bSymLast;
  logic [127:0] bSyn;
  logic         bSynValid;
  logic         bErr;
  logic         bLenErr;
  logic         bBusy;

  int           total = 0;
  int           bad = 0;
  int           pulseCount = 0;
  int           expectedPulses = 0;
  logic [3:0]   frameBuf [0:19];

  gf_syndrome_accum #(.M(4), .POLY(5'h13), .NSYN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_valid_i (symValid),
    .sym_i       (sym),
    .sym_last_i  (symLast),
    .syn_o       (syn),
    .syn_valid_o (synValid),
    .err_o       (err),
    .len_err_o   (lenErr),
    .busy_o      (busy)
  );

  gf_syndrome_accum #(.M(8), .POLY(9'h11D), .NSYN(16)) dutWide (
    .clk         (clk),
    .rst         (rst),
    .sym_valid_i (bSymValid),
    .sym_i       (bSym),
    .sym_last_i  (bSymLast),
    .syn_o       (bSyn),
    .syn_valid_o (bSynValid),
    .err_o       (bErr),
    .len_err_o   (bLenErr),
    .busy_o      (bBusy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Count every completion pulse so stray or missing pulses show up.
  always @(negedge clk) begin
    if (synValid) pulseCount++;
  end

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Check a completion in the cycle after the last symbol, then that the
  // pulse drops one cycle later.
  task automatic checkFrame(input string tag, input logic [15:0] expSyn,
                            input logic expErr, input logic expLen);
    checkOutput({tag, ".valid"}, 128'(synValid), 128'(1));
    checkOutput({tag, ".syn"}, 128'(syn), 128'(expSyn));
    checkOutput({tag, ".err"}, 128'(err), 128'(expErr));
    checkOutput({tag, ".lenerr"}, 128'(lenErr), 128'(expLen));
    checkOutput({tag, ".busy"}, 128'(busy), 128'(0));
    @(negedge clk);
    checkOutput({tag, ".pulse1"}, 128'(synValid), 128'(0));
  endtask

  task automatic loadFrame(input int len, input logic [3:0] val);
    for (int i = 0; i < len; i++) frameBuf[i] = val;
  endtask

  // Drive frameBuf[0..len-1] back to back with last on the final symbol.
  task automatic applyStimulus(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      symValid = 1'b1;
      sym      = frameBuf[i];
      symLast  = (i == len - 1);
    end
    @(negedge clk);
    symValid = 1'b0;
    symLast  = 1'b0;
    sym      = 4'h0;
    expectedPulses++;
  endtask

  initial begin
    rst       = 1'b1;
    symValid  = 1'b0;
    sym       = 4'h0;
    symLast   = 1'b0;
    bSymValid = 1'b0;
    bSym      = 8'h00;
    bSymLast  = 1'b0;
    #1;
    checkOutput("reset.syn", 128'(syn), 128'(0));
    checkOutput("reset.valid", 128'(synValid), 128'(0));
    checkOutput("reset.err", 128'(err), 128'(0));
    checkOutput("reset.lenerr", 128'(lenErr), 128'(0));
    checkOutput("reset.busy", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single symbol: every syndrome equals the symbol.
    loadFrame(1, 4'h1);
    applyStimulus(1);
    checkFrame("single", 16'h1111, 1'b1, 1'b0);

    // [1,0]: S_j = alpha^j = 2,4,8,3.
    loadFrame(2, 4'h0);
    frameBuf[0] = 4'h1;
    applyStimulus(2);
    checkFrame("two", 16'h3842, 1'b1, 1'b0);

    // [8,0]: S_j = alpha^(3+j) = 3,6,C,B; exercises reduction.
    frameBuf[0] = 4'h8;
    applyStimulus(2);
    checkFrame("reduce", 16'hBC63, 1'b1, 1'b0);

    // [1,1,1]: S_j = alpha^2j + alpha^j + 1 = 7,6,5,7.
    loadFrame(3, 4'h1);
    applyStimulus(3);
    checkFrame("three", 16'h7567, 1'b1, 1'b0);

    // 15 zeros: zero codeword.
    loadFrame(15, 4'h0);
    applyStimulus(15);
    checkFrame("zeros15", 16'h0000, 1'b0, 1'b0);

    // 15 ones: geometric sum of a full cycle of alpha^j is zero.
    loadFrame(15, 4'h1);
    applyStimulus(15);
    checkFrame("ones15", 16'h0000, 1'b0, 1'b0);

    // 16 zeros: one symbol too many.
    loadFrame(16, 4'h0);
    applyStimulus(16);
    checkFrame("zeros16", 16'h0000, 1'b0, 1'b1);

    // Gap of three cycles (with a stray unqualified last), then back to back.
    @(negedge clk);
    symValid = 1'b1; sym = 4'h1; symLast = 1'b0;
    @(negedge clk);
    symValid = 1'b0; sym = 4'hF; symLast = 1'b1;
    checkOutput("gap.busy", 128'(busy), 128'(1));
    repeat (2) @(negedge clk);
    checkOutput("gap.hold", 128'(synValid), 128'(0));
    @(negedge clk);
    symValid = 1'b1; sym = 4'h0; symLast = 1'b1;
    checkOutput("gap.busy2", 128'(busy), 128'(1));
    @(negedge clk);
    symValid = 1'b1; sym = 4'h1; symLast = 1'b1;
    expectedPulses++;
    checkOutput("b2b.first.valid", 128'(synValid), 128'(1));
    checkOutput("b2b.first.syn", 128'(syn), 128'(16'h3842));
    @(negedge clk);
    symValid = 1'b0; sym = 4'h0; symLast = 1'b0;
    expectedPulses++;
    checkFrame("b2b.second", 16'h1111, 1'b1, 1'b0);

    // 17 ones: counter saturates, S_j = alpha^j + 1 = 3,5,9,2.
    loadFrame(17, 4'h1);
    applyStimulus(17);
    checkFrame("ones17", 16'h2953, 1'b1, 1'b1);

    // Reset mid-frame: outputs clear at once and the partial frame vanishes.
    @(negedge clk);
    symValid = 1'b1; sym = 4'h5; symLast = 1'b0;
    @(negedge clk);
    sym = 4'h7;
    checkOutput("rstmid.busy", 128'(busy), 128'(1));
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid.syn", 128'(syn), 128'(0));
    checkOutput("rstmid.err", 128'(err), 128'(0));
    checkOutput("rstmid.lenerr", 128'(lenErr), 128'(0));
    checkOutput("rstmid.busy0", 128'(busy), 128'(0));
    @(negedge clk);
    symValid = 1'b0; sym = 4'h0; rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid.nopulse", 128'(synValid), 128'(0));
    loadFrame(1, 4'h1);
    applyStimulus(1);
    checkFrame("postrst", 16'h1111, 1'b1, 1'b0);

    checkOutput("pulses", 128'(pulseCount), 128'(expectedPulses));

    // GF(256) instance: [01,00] gives S_j = alpha^j.
    @(negedge clk);
    bSymValid = 1'b1; bSym = 8'h01; bSymLast = 1'b0;
    @(negedge clk);
    bSym = 8'h00; bSymLast = 1'b1;
    @(negedge clk);
    bSymValid = 1'b0; bSymLast = 1'b0;
    checkOutput("wide.valid", 128'(bSynValid), 128'(1));
    checkOutput("wide.s1", 128'(bSyn[7:0]), 128'(8'h02));
    checkOutput("wide.s8", 128'(bSyn[63:56]), 128'(8'h1D));
    checkOutput("wide.s12", 128'(bSyn[95:88]), 128'(8'hCD));
    checkOutput("wide.s16", 128'(bSyn[127:120]), 128'(8'h4C));
    checkOutput("wide.err", 128'(bErr), 128'(1));
    checkOutput("wide.lenerr", 128'(bLenErr), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
